// File: rtl/brc_pipe_if.sv
// brc_pipe_if: handshake and data bundle for the pipelined branch comparator.
//   i_valid / o_ready          : input beat handshake (o_ready = global advance)
//   i_rs1_data / i_rs2_data    : operands, WIDTH bits
//   i_funct3                   : RV32I branch funct3
//   i_flush                    : kill every in-flight beat at the next edge
//   o_valid / i_ready          : result handshake
//   o_br_equal/less/taken/illegal : comparison results
// The slave modport is the comparator; the master modport is its surroundings.
interface brc_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic [2:0]       i_funct3;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_equal;
    logic             o_br_less;
    logic             o_br_taken;
    logic             o_br_illegal;

    modport master (
        output i_valid, i_rs1_data, i_rs2_data, i_funct3, i_flush, i_ready,
        input  o_ready, o_valid, o_br_equal, o_br_less, o_br_taken, o_br_illegal
    );

    modport slave (
        input  i_valid, i_rs1_data, i_rs2_data, i_funct3, i_flush, i_ready,
        output o_ready, o_valid, o_br_equal, o_br_less, o_br_taken, o_br_illegal
    );
endinterface

// File: rtl/brc_pipe.sv
// brc_pipe: pipelined RV32I branch comparator with valid/ready, stall and flush.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : brc_pipe_if.slave (operands, funct3, handshakes, result flags)
// Stage 1 registers per-nibble lt/gt flags; the next stage collapses them
// MSB-first into a single lt/gt pair (stage 1 does both when STAGES = 1).
// Later stages only carry the collapsed result. A beat accepted at edge N
// is visible after edge N+STAGES-1 while the pipe keeps advancing.
module brc_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic     i_clk,
    input logic     i_rst,
    brc_pipe_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;

    typedef struct packed {
        logic           valid;
        logic [2:0]     funct3;
        logic           sign_a;
        logic           sign_b;
        logic [NIB-1:0] lt;
        logic [NIB-1:0] gt;
    } slot_t;

    slot_t slots [STAGES];
    slot_t nxt   [STAGES];
    slot_t raw;
    slot_t last;
    logic  en;

    // Highest unequal nibble decides; scanning upward lets it overwrite.
    function automatic logic [1:0] reduce_msb_first(input logic [NIB-1:0] lt,
                                                    input logic [NIB-1:0] gt);
        logic l;
        logic g;
        l = 1'b0;
        g = 1'b0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (lt[i] | gt[i]) begin
                l = lt[i];
                g = gt[i];
            end
        end
        return {l, g};
    endfunction

    // Collapsed result lives in bit 0; idempotent on already-collapsed slots.
    function automatic slot_t collapse(input slot_t s);
        slot_t      r;
        logic [1:0] lg;
        r     = s;
        lg    = reduce_msb_first(s.lt, s.gt);
        r.lt  = '0;
        r.gt  = '0;
        r.lt[0] = lg[1];
        r.gt[0] = lg[0];
        return r;
    endfunction

    always_comb begin
        raw        = '0;
        raw.valid  = bus.i_valid;
        raw.funct3 = bus.i_funct3;
        raw.sign_a = bus.i_rs1_data[WIDTH-1];
        raw.sign_b = bus.i_rs2_data[WIDTH-1];
        for (int unsigned i = 0; i < NIB; i++) begin
            raw.lt[i] = bus.i_rs1_data[4*i +: 4] < bus.i_rs2_data[4*i +: 4];
            raw.gt[i] = bus.i_rs1_data[4*i +: 4] > bus.i_rs2_data[4*i +: 4];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt[k] = '0;
        end
        nxt[0] = (STAGES == 1) ? collapse(raw) : raw;
        for (int unsigned k = 1; k < STAGES; k++) begin
            nxt[k] = (k == 1) ? collapse(slots[0]) : slots[k-1];
        end
    end

    assign last = slots[STAGES-1];
    assign en   = ~last.valid | bus.i_ready;

    // Flush overrides the stall: valid bits clear even when en = 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                slots[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (en) begin
                    slots[k] <= nxt[k];
                end
                if (bus.i_flush) begin
                    slots[k].valid <= 1'b0;
                end
            end
        end
    end

    logic [1:0] lg_out;
    logic       less_u;
    logic       equal;
    logic       less;
    logic       taken;
    logic       illegal;

    always_comb begin
        lg_out  = reduce_msb_first(last.lt, last.gt);
        less_u  = lg_out[1];
        equal   = ~lg_out[1] & ~lg_out[0];
        illegal = (last.funct3[2:1] == 2'b01);
        if (last.funct3[1] || (last.sign_a == last.sign_b)) begin
            less = less_u;
        end else begin
            less = last.sign_a;
        end
        taken = 1'b0;
        case (last.funct3)
            3'b000:         taken = equal;
            3'b001:         taken = ~equal;
            3'b100, 3'b110: taken = less;
            3'b101, 3'b111: taken = ~less;
            default:        taken = 1'b0;
        endcase
    end

    // Flags are gated by o_valid so idle/reset outputs read as zero.
    assign bus.o_ready      = en;
    assign bus.o_valid      = last.valid;
    assign bus.o_br_equal   = last.valid & equal;
    assign bus.o_br_less    = last.valid & less;
    assign bus.o_br_taken   = last.valid & taken;
    assign bus.o_br_illegal = last.valid & illegal;
endmodule

// File: tb/tb_brc_pipe.sv
// tb_brc_pipe: directed checks on WIDTH=32/STAGES=2 plus a random sweep on
// WIDTH=64 with STAGES=1 and STAGES=4, each DUT backed by a result queue.
module tb_brc_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    brc_pipe_if #(.WIDTH(32)) b32 ();
    brc_pipe_if #(.WIDTH(64)) b1 ();
    brc_pipe_if #(.WIDTH(64)) b4 ();

    brc_pipe #(.WIDTH(32), .STAGES(2)) u32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));
    brc_pipe #(.WIDTH(64), .STAGES(1)) u1  (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
    brc_pipe #(.WIDTH(64), .STAGES(4)) u4  (.i_clk(clk), .i_rst(rst), .bus(b4.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Returns {equal, less, taken, illegal}.
    function automatic logic [3:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] f, input int unsigned w);
        logic [63:0] sa;
        logic [63:0] sb;
        logic eq, less, taken, ill;
        sa  = a << (64 - w);
        sb  = b << (64 - w);
        eq  = (a == b);
        ill = (f[2:1] == 2'b01);
        less = f[1] ? (a < b) : ($signed(sa) < $signed(sb));
        case (f)
            3'b000:         taken = eq;
            3'b001:         taken = !eq;
            3'b100, 3'b110: taken = less;
            3'b101, 3'b111: taken = !less;
            default:        taken = 1'b0;
        endcase
        return {eq, less, taken, ill};
    endfunction

    logic [3:0] q32[$];
    logic [3:0] q1[$];
    logic [3:0] q4[$];

    always @(negedge clk or posedge rst) begin
        if (rst) q32.delete();
        else begin
            if (b32.o_valid && b32.i_ready) begin
                check("sb32_pending", q32.size() > 0, 1);
                if (q32.size() > 0)
                    check("sb32", {b32.o_br_equal, b32.o_br_less, b32.o_br_taken, b32.o_br_illegal},
                          q32.pop_front());
            end
            if (b32.i_flush) q32.delete();
            else if (b32.i_valid && b32.o_ready)
                q32.push_back(model({32'h0, b32.i_rs1_data}, {32'h0, b32.i_rs2_data}, b32.i_funct3, 32));
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) q1.delete();
        else begin
            if (b1.o_valid && b1.i_ready) begin
                check("sb1_pending", q1.size() > 0, 1);
                if (q1.size() > 0)
                    check("sb1", {b1.o_br_equal, b1.o_br_less, b1.o_br_taken, b1.o_br_illegal},
                          q1.pop_front());
            end
            if (b1.i_flush) q1.delete();
            else if (b1.i_valid && b1.o_ready)
                q1.push_back(model(b1.i_rs1_data, b1.i_rs2_data, b1.i_funct3, 64));
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) q4.delete();
        else begin
            if (b4.o_valid && b4.i_ready) begin
                check("sb4_pending", q4.size() > 0, 1);
                if (q4.size() > 0)
                    check("sb4", {b4.o_br_equal, b4.o_br_less, b4.o_br_taken, b4.o_br_illegal},
                          q4.pop_front());
            end
            if (b4.i_flush) q4.delete();
            else if (b4.i_valid && b4.o_ready)
                q4.push_back(model(b4.i_rs1_data, b4.i_rs2_data, b4.i_funct3, 64));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f);
        b32.i_valid    = v;
        b32.i_rs1_data = a;
        b32.i_rs2_data = b;
        b32.i_funct3   = f;
    endtask

    function automatic logic [4:0] out32();
        return {b32.o_valid, b32.o_br_equal, b32.o_br_less, b32.o_br_taken, b32.o_br_illegal};
    endfunction

    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rf;
    logic        rv, rr, rfl;

    initial begin
        drive32(0, '0, '0, '0);
        b32.i_flush = 0; b32.i_ready = 1;
        b1.i_valid = 0; b1.i_rs1_data = '0; b1.i_rs2_data = '0; b1.i_funct3 = '0;
        b1.i_flush = 0; b1.i_ready = 1;
        b4.i_valid = 0; b4.i_rs1_data = '0; b4.i_rs2_data = '0; b4.i_funct3 = '0;
        b4.i_flush = 0; b4.i_ready = 1;

        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1 rst = 0;
        b32.i_ready = 0;
        #1;
        check("rst_o_valid", b32.o_valid, 0);
        check("rst_flags", out32(), 0);
        check("rst_o_ready", b32.o_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_o_valid", b32.o_valid, 0);
        end

        // back-to-back stream
        b32.i_ready = 1;
        drive32(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        tick();
        check("stream_not_early", b32.o_valid, 0);
        drive32(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        tick();
        check("stream_blt", out32(), 5'b1_0110);
        drive32(1, 32'h1234_5678, 32'h1234_5678, 3'b000);
        tick();
        check("stream_bltu", out32(), 5'b1_0000);
        drive32(0, '0, '0, '0);
        tick();
        check("stream_beq", out32(), 5'b1_1010);
        tick();
        check("stream_drained", b32.o_valid, 0);

        // backpressure with two beats in flight
        drive32(1, 32'd5, 32'd9, 3'b101);
        tick();
        drive32(1, 32'd7, 32'd7, 3'b001);
        tick();
        drive32(0, '0, '0, '0);
        b32.i_ready = 0;
        #1;
        check("bp_o_ready", b32.o_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", out32(), 5'b1_0100);
            tick();
        end
        check("bp_hold_last", out32(), 5'b1_0100);
        b32.i_ready = 1;
        tick();
        check("bp_second", out32(), 5'b1_1000);
        tick();
        check("bp_empty", b32.o_valid, 0);

        // flush with a new beat in the same cycle
        drive32(1, 32'd9, 32'd5, 3'b111);
        tick();
        drive32(1, 32'd3, 32'd4, 3'b000);
        tick();
        drive32(1, 32'd1, 32'd1, 3'b000);
        b32.i_flush = 1;
        b32.i_ready = 0;
        tick();
        check("flush_o_valid", b32.o_valid, 0);
        drive32(0, '0, '0, '0);
        b32.i_flush = 0;
        b32.i_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_quiet", b32.o_valid, 0);
        end

        // illegal funct3 after flush
        drive32(1, 32'd5, 32'd9, 3'b011);
        tick();
        check("illegal_not_early", b32.o_valid, 0);
        drive32(0, '0, '0, '0);
        tick();
        check("illegal", out32(), 5'b1_0101);
        tick();
        check("illegal_drained", b32.o_valid, 0);

        // signed/unsigned extremes
        drive32(1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
        tick();
        drive32(1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b110);
        tick();
        check("ext_signed", out32(), 5'b1_0110);
        drive32(0, '0, '0, '0);
        tick();
        check("ext_unsigned", out32(), 5'b1_0000);
        tick();

        // asynchronous reset with a full pipe
        drive32(1, 32'd1, 32'd2, 3'b100);
        tick();
        drive32(1, 32'd2, 32'd1, 3'b100);
        tick();
        check("pre_rst_valid", b32.o_valid, 1);
        #1 rst = 1;
        #1;
        check("async_rst_valid", b32.o_valid, 0);
        check("async_rst_flags", out32(), 0);
        #1 rst = 0;
        drive32(0, '0, '0, '0);
        tick();
        check("post_rst_quiet1", b32.o_valid, 0);
        tick();
        check("post_rst_quiet2", b32.o_valid, 0);

        // random sweep on the 64-bit instances
        for (int i = 0; i < 14000; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (64'h1 << $urandom_range(0, 63));
                2: rb = {~ra[63], ra[62:0]};
                default: rb = {$urandom, $urandom};
            endcase
            rf  = 3'($urandom_range(0, 7));
            rv  = ($urandom_range(0, 4) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            rfl = ($urandom_range(0, 31) == 0);
            b1.i_valid = rv; b1.i_rs1_data = ra; b1.i_rs2_data = rb; b1.i_funct3 = rf;
            b1.i_ready = rr; b1.i_flush = rfl;
            b4.i_valid = rv; b4.i_rs1_data = ra; b4.i_rs2_data = rb; b4.i_funct3 = rf;
            b4.i_ready = rr; b4.i_flush = rfl;
            tick();
        end
        b1.i_valid = 0; b1.i_flush = 0; b1.i_ready = 1;
        b4.i_valid = 0; b4.i_flush = 0; b4.i_ready = 1;
        repeat (8) tick();
        check("sb32_drained", q32.size(), 0);
        check("sb1_drained", q1.size(), 0);
        check("sb4_drained", q4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
